// File: rtl/cam_capture_maxis.sv
// Camera byte-pair capture to an AXI4-Stream video master.
// Two bytes per pixel (low first), TUSER on frame start, TLAST on line end.
module cam_capture_maxis #(
  parameter int X_RES = 640,
  parameter int Y_RES = 480
) (
  input  logic        i_pclk,
  input  logic        i_resetn,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [15:0] M_AXIS_VIDEO_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_VIDEO_TREADY,
  output logic        M_AXIS_VIDEO_TUSER,
  output logic        M_AXIS_VIDEO_TLAST
);

  localparam int XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_RES - 1);

  localparam logic [0:0] WAIT_FRAME = 1'b0;
  localparam logic [0:0] CAPTURE    = 1'b1;

  logic [0:0]    r_state;
  logic          r_vsync_d;
  logic          r_phase;
  logic [7:0]    r_low;
  logic [XW-1:0] r_pix;
  logic [YW-1:0] r_line;
  logic          r_sof;
  logic [15:0]   r_tdata;
  logic          r_tvalid;
  logic          r_tuser;
  logic          r_tlast;

  logic w_vs_fall;
  logic w_cap;
  logic w_byte;
  logic w_beat;
  logic w_eol;
  logic w_eof;
  logic w_unused;

  // The camera cannot be stalled, so the sink ready is deliberately ignored.
  assign w_unused = M_AXIS_VIDEO_TREADY;

  // Decode frame/line events from the current sample and stored state.
  always_comb begin
    w_vs_fall = r_vsync_d & ~i_vsync;
    w_cap     = (r_state == CAPTURE) & i_enable;
    w_byte    = w_cap & i_href & ~i_vsync;
    w_beat    = w_byte & r_phase;
    w_eol     = w_beat & (r_pix == X_LAST);
    w_eof     = w_eol & (r_line == Y_LAST);
  end

  // Frame-level FSM: arm on vsync fall, drop on disable or after last line.
  always_ff @(posedge i_pclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= WAIT_FRAME;
      r_vsync_d <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      unique case (r_state)
        WAIT_FRAME:
          if (w_vs_fall && i_enable) r_state <= CAPTURE;
        CAPTURE:
          if (!i_enable || w_eof) r_state <= WAIT_FRAME;
        default:
          r_state <= WAIT_FRAME;
      endcase
    end
  end

  // Byte pairing, pixel/line counters and the pending start-of-frame flag.
  always_ff @(posedge i_pclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_phase <= 1'b0;
      r_low   <= 8'h00;
      r_pix   <= '0;
      r_line  <= '0;
      r_sof   <= 1'b0;
    end else begin
      if (!w_byte) begin
        r_phase <= 1'b0;
        r_pix   <= '0;
      end else begin
        r_phase <= ~r_phase;
        if (!r_phase) r_low <= i_data;
        if (w_beat) r_pix <= w_eol ? '0 : r_pix + 1'b1;
      end
      if (i_vsync) begin
        r_line <= '0;
        r_sof  <= 1'b1;
      end else begin
        if (w_eol) r_line <= w_eof ? '0 : r_line + 1'b1;
        if (w_beat) r_sof <= 1'b0;
      end
    end
  end

  // Registered stream outputs; sidebands only ever accompany a valid beat.
  always_ff @(posedge i_pclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_tdata  <= 16'h0000;
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      r_tvalid <= w_beat;
      r_tuser  <= w_beat & r_sof;
      r_tlast  <= w_eol;
      if (w_beat) r_tdata <= {i_data, r_low};
    end
  end

  assign M_AXIS_VIDEO_TDATA = r_tdata;
  assign M_AXIS_TVALID      = r_tvalid;
  assign M_AXIS_VIDEO_TUSER = r_tuser;
  assign M_AXIS_VIDEO_TLAST = r_tlast;

endmodule

// File: tb/tb_cam_capture_maxis.sv
// Testbench for cam_capture_maxis.
// Random camera frames compared against an expected-beat list.
module tb_cam_capture_maxis;

  localparam int XR = 64;
  localparam int YR = 3;

  logic        pclk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        tready = 1'b1;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;

  int checks = 0;
  int errors = 0;
  int stray = 0;

  // {tuser, tlast, tdata}
  logic [17:0] rx_q[$];
  logic [17:0] exp_q[$];

  cam_capture_maxis #(.X_RES(XR), .Y_RES(YR)) dut (
    .i_pclk              (pclk),
    .i_resetn            (resetn),
    .i_enable            (enable),
    .i_vsync             (vsync),
    .i_href              (href),
    .i_data              (data),
    .M_AXIS_VIDEO_TDATA  (tdata),
    .M_AXIS_TVALID       (tvalid),
    .M_AXIS_VIDEO_TREADY (tready),
    .M_AXIS_VIDEO_TUSER  (tuser),
    .M_AXIS_VIDEO_TLAST  (tlast)
  );

  always #20 pclk = ~pclk;

  always @(negedge pclk) begin
    if (tvalid) rx_q.push_back({tuser, tlast, tdata});
    else if (tuser || tlast) stray++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      href = 1'b0;
    end
  endtask

  task automatic vsync_pulse(input int n);
    repeat (n) begin
      @(negedge pclk);
      vsync = 1'b1;
      href = 1'b0;
    end
    @(negedge pclk);
    vsync = 1'b0;
    idle(16);
  endtask

  task automatic send_px(input logic [15:0] px);
    @(negedge pclk);
    href = 1'b1;
    data = px[7:0];
    @(negedge pclk);
    data = px[15:8];
  endtask

  // Model: the first pixel after vsync carries TUSER, pixel XR-1 of
  // each full line carries TLAST, data arrives in camera order.
  task automatic send_frame(input bit fix, input logic [15:0] first,
                            input bit expect_out);
    logic [15:0] px;
    for (int l = 0; l < YR; l++) begin
      for (int p = 0; p < XR; p++) begin
        px = (fix && l == 0 && p == 0) ? first : 16'($urandom);
        send_px(px);
        if (expect_out)
          exp_q.push_back({(l == 0 && p == 0), (p == XR - 1), px});
      end
      idle(8);
    end
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge pclk);
    checks++;
    if ({tvalid, tuser, tlast} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 000", {tvalid, tuser, tlast});
    end
    checks++;
    if (tdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0000", tdata);
    end
    resetn = 1'b1;
    clear_q();
    send_frame(1'b0, 16'h0, 1'b0);
    checks++;
    if (rx_q.size() !== 0) begin
      errors++;
      $display("FAIL no_vsync: got %0d beats exp 0", rx_q.size());
    end
  endtask

  task automatic test_frame();
    int n;
    clear_q();
    vsync_pulse(128);
    send_frame(1'b1, 16'h1234, 1'b1);
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL frame_count: got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_beat%0d: got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int sofs;
    clear_q();
    for (int f = 0; f < 3; f++) begin
      vsync_pulse(128);
      send_frame(1'b0, 16'h0, 1'b1);
    end
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    sofs = 0;
    for (int i = 0; i < n; i++) begin
      if (rx_q[i][17]) sofs++;
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (sofs !== 3) begin
      errors++;
      $display("FAIL b2b_tuser: got %0d exp 3", sofs);
    end
  endtask

  task automatic test_short_odd();
    logic [15:0] px;
    int n;
    clear_q();
    vsync_pulse(128);
    for (int p = 0; p < 10; p++) begin
      px = 16'($urandom);
      send_px(px);
      exp_q.push_back({(p == 0), 1'b0, px});
    end
    @(negedge pclk);
    data = 8'($urandom);
    idle(8);
    send_frame(1'b0, 16'h0, 1'b1);
    exp_q[10][17] = 1'b0;
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL short_count: got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_beat%0d: got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_enable();
    logic [15:0] px;
    clear_q();
    enable = 1'b0;
    vsync_pulse(128);
    send_frame(1'b0, 16'h0, 1'b0);
    checks++;
    if (rx_q.size() !== 0) begin
      errors++;
      $display("FAIL dis_frame: got %0d beats exp 0", rx_q.size());
    end
    vsync_pulse(64);
    for (int p = 0; p < XR; p++) send_px(16'($urandom));
    idle(8);
    enable = 1'b1;
    for (int l = 1; l < YR; l++) begin
      for (int p = 0; p < XR; p++) send_px(16'($urandom));
      idle(8);
    end
    checks++;
    if (rx_q.size() !== 0) begin
      errors++;
      $display("FAIL en_midframe: got %0d beats exp 0", rx_q.size());
    end
    vsync_pulse(128);
    px = 16'($urandom);
    send_px(px);
    @(negedge pclk);
    data = 8'($urandom);
    @(negedge pclk);
    data = 8'($urandom);
    enable = 1'b0;
    @(negedge pclk);
    enable = 1'b1;
    for (int p = 2; p < XR; p++) send_px(16'($urandom));
    idle(8);
    checks++;
    if (rx_q.size() !== 1) begin
      errors++;
      $display("FAIL en_midpixel_count: got %0d exp 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== {2'b10, px}) begin
        errors++;
        $display("FAIL en_midpixel_beat: got %h exp %h", rx_q[0], {2'b10, px});
      end
    end
  endtask

  task automatic test_reset_midline();
    int n;
    clear_q();
    vsync_pulse(128);
    send_px(16'h5aa5);
    @(negedge pclk);
    data = 8'h11;
    checks++;
    if (tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_valid: got %b exp 1", tvalid);
    end
    #5 resetn = 1'b0;
    #1;
    checks++;
    if ({tdata, tvalid, tuser, tlast} !== 19'h0) begin
      errors++;
      $display("FAIL rst_midline: got %h exp 0", {tdata, tvalid, tuser, tlast});
    end
    @(negedge pclk);
    resetn = 1'b1;
    clear_q();
    for (int p = 3; p < XR; p++) send_px(16'($urandom));
    idle(8);
    for (int l = 1; l < YR; l++) begin
      for (int p = 0; p < XR; p++) send_px(16'($urandom));
      idle(8);
    end
    checks++;
    if (rx_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_resume_early: got %0d beats exp 0", rx_q.size());
    end
    vsync_pulse(128);
    send_frame(1'b0, 16'h0, 1'b1);
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rst_count: got %0d exp %0d", rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_beat%0d: got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL stray_sideband: got %0d exp 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_short_odd();
    test_enable();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
